// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings, header width
// and the helper that says which states take bytes from the host stream.
package inst_mem_loader_pkg;

  localparam int HDR_W      = 16;
  localparam int BYTE_W_DEF = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic logic accepts_bytes(input logic [2:0] s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte stream from the host link plus the instruction-RAM write port, as seen by the loader
// (master) and by the surrounding system (slave).
interface inst_mem_loader_if
  import inst_mem_loader_pkg::*;
#(
  parameter int instructionW = 32,
  parameter int addrW        = 16,
  parameter int BYTE_W       = BYTE_W_DEF
);
  logic [BYTE_W-1:0]       byteIn;
  logic                    byteValid;
  logic                    byteReady;
  logic                    memWEn;
  logic [addrW-1:0]        memAddr;
  logic [instructionW-1:0] memData;

  modport master (
    input  byteIn, byteValid,
    output byteReady, memWEn, memAddr, memData
  );

  modport slave (
    output byteIn, byteValid,
    input  byteReady, memWEn, memAddr, memData
  );
endinterface

// File: rtl/inst_mem_loader_word_asm.sv
// Packs four stream bytes LSB-first into one word; word_o already contains the byte
// being accepted so the caller can latch a complete word on the last-byte strobe.
module loader_word_asm
  import inst_mem_loader_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic [4*BYTE_W-1:0]   word_o,
  output logic                  last_o
);
  logic [1:0]          idx_q, idx_d;
  logic [4*BYTE_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (vld_i) begin
      word_d[int'(idx_q) * BYTE_W +: BYTE_W] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  assign word_o = word_d;
  assign last_o = vld_i & ~clr_i & (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// Loads an instruction image from a host byte stream into instruction RAM while holding
// the CPU in reset; verifies an XOR checksum and pulses done when finished.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int instructionW = 32,
  parameter int addrW        = 16,
  parameter int BYTE_W       = BYTE_W_DEF
) (
  input  logic               sysCLK,
  input  logic               resetN,
  input  logic               startLoad,
  input  logic [addrW-1:0]   loadBase,
  inst_mem_loader_if.master  bus,
  output logic               cpuResetN,
  output logic               busy,
  output logic               done,
  output logic               csumErr
);
  logic [2:0]              state_q, state_d;
  logic [HDR_W-1:0]        cnt_q, cnt_d;
  logic [addrW-1:0]        addr_q, addr_d;
  logic [instructionW-1:0] data_q, data_d;
  logic [BYTE_W-1:0]       xor_q, xor_d;
  logic                    err_q, err_d;
  logic                    rdy_q, we_q, cpurst_q, busy_q, done_q;

  logic                    xfer, start_acc, data_xfer, last;
  logic [4*BYTE_W-1:0]     word;

  assign xfer      = bus.byteValid & rdy_q;
  assign start_acc = startLoad & (state_q == S_IDLE);
  assign data_xfer = xfer & (state_q == S_DATA);

  loader_word_asm #(.BYTE_W(BYTE_W)) u_asm (
    .clk    (sysCLK),
    .rst_n  (resetN),
    .clr_i  (start_acc),
    .vld_i  (data_xfer),
    .byte_i (bus.byteIn),
    .word_o (word),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    xor_d   = xor_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_acc) begin
        state_d = S_LEN_LO;
        addr_d  = loadBase;
        xor_d   = '0;
        err_d   = 1'b0;
      end
      S_LEN_LO: if (xfer) begin
        cnt_d   = HDR_W'(bus.byteIn);
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) begin
        cnt_d   = HDR_W'({bus.byteIn, cnt_q[BYTE_W-1:0]});
        state_d = (cnt_d == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (xfer) begin
        xor_d = xor_q ^ bus.byteIn;
        if (last) begin
          data_d  = word;
          state_d = S_WRITE;
        end
      end
      // Address and word count advance as the write retires; the RAM sees the old address.
      S_WRITE: begin
        addr_d  = addr_q + addrW'(1);
        cnt_d   = cnt_q - HDR_W'(1);
        state_d = (cnt_q == HDR_W'(1)) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (xfer) begin
        err_d   = (bus.byteIn != xor_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      xor_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      we_q     <= 1'b0;
      cpurst_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      xor_q    <= xor_d;
      err_q    <= err_d;
      rdy_q    <= accepts_bytes(state_d);
      we_q     <= (state_d == S_WRITE);
      cpurst_q <= (state_d == S_IDLE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.byteReady = rdy_q;
  assign bus.memWEn    = we_q;
  assign bus.memAddr   = addr_q;
  assign bus.memData   = data_q;
  assign cpuResetN     = cpurst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign csumErr       = err_q;
endmodule
